// File: rtl/adc_s101_pkg.sv
// Shared types and constants for the ADCxx1S101 multi-channel frame driver.
// Holds the frame state encoding, default tick counts and counter sizing helper.
package adc_s101_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    SHIFT,
    TRAIL,
    QUIET
  } adcState_e;

  localparam int DEF_ADC_RES     = 8;
  localparam int DEF_TICKS_LEAD  = 3;
  localparam int DEF_TICKS_TRAIL = 5;
  localparam int DEF_TICKS_QUIET = 4;

  // 20 MHz with default ticks gives a 20-cycle frame, i.e. 1 Msps.
  localparam int REF_CLK_HZ = 20_000_000;

  function automatic int cntWidth(input int maxCount);
    return (maxCount < 1) ? 1 : $clog2(maxCount + 1);
  endfunction

endpackage

// File: rtl/adc_s101_shift.sv
// One channel: serial-in shift register (MSB first) with optional bit inversion
// and a parallel load into the result holding register.
module adc_s101_shift
  import adc_s101_pkg::*;
#(
  parameter int ADC_RES     = DEF_ADC_RES,
  parameter bit MISO_INVERT = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               shiftEn,
  input  logic               load,
  input  logic               misoBit,
  output logic [ADC_RES-1:0] dataOut
);

  logic               inBit;
  logic [ADC_RES-1:0] shiftReg;
  logic [ADC_RES-1:0] shiftNext;

  assign inBit = misoBit ^ MISO_INVERT;

  // A 1-bit converter has no older bits to carry along.
  if (ADC_RES == 1) begin : gOne
    assign shiftNext = inBit;
  end else begin : gMany
    assign shiftNext = {shiftReg[ADC_RES-2:0], inBit};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shiftReg <= '0;
      dataOut  <= '0;
    end else begin
      if (shiftEn) shiftReg <= shiftNext;
      if (load)    dataOut  <= shiftReg;
    end
  end

endmodule

// File: rtl/adc_s101_array.sv
// Shared chip-select frame generator for NUM_CH lockstep ADCxx1S101 converters,
// with single-shot / continuous modes and a valid/ready result handshake.
module adc_s101_array
  import adc_s101_pkg::*;
#(
  parameter int ADC_RES     = DEF_ADC_RES,
  parameter int NUM_CH      = 1,
  parameter int TICKS_LEAD  = DEF_TICKS_LEAD,
  parameter int TICKS_TRAIL = DEF_TICKS_TRAIL,
  parameter int TICKS_QUIET = DEF_TICKS_QUIET,
  parameter bit MISO_INVERT = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      continuous,
  input  logic [NUM_CH-1:0]         miso,
  output logic                      cs,
  output logic [NUM_CH*ADC_RES-1:0] data_out,
  output logic                      data_valid,
  input  logic                      data_ready,
  output logic                      overrun,
  output logic                      busy
);

  localparam int MAX_LT  = (TICKS_LEAD > TICKS_TRAIL) ? TICKS_LEAD : TICKS_TRAIL;
  localparam int MAX_RQ  = (ADC_RES > TICKS_QUIET) ? ADC_RES : TICKS_QUIET;
  localparam int MAX_CNT = (MAX_LT > MAX_RQ) ? MAX_LT : MAX_RQ;
  localparam int CW      = cntWidth(MAX_CNT);

  localparam logic [CW-1:0] LEAD_CNT  = CW'(TICKS_LEAD);
  localparam logic [CW-1:0] RES_CNT   = CW'(ADC_RES);
  localparam logic [CW-1:0] TRAIL_CNT = CW'(TICKS_TRAIL);
  localparam logic [CW-1:0] QUIET_CNT = CW'(TICKS_QUIET);
  localparam logic [CW-1:0] ONE       = CW'(1);

  adcState_e state;
  logic [CW-1:0] cnt;
  logic cntDone, shiftEn, loadNow, goFrame, accept;
  logic [NUM_CH-1:0][ADC_RES-1:0] chData;

  assign cntDone = (cnt == ONE);
  assign shiftEn = (state == SHIFT);
  assign loadNow = (state == TRAIL) && cntDone;
  assign goFrame = start | continuous;
  assign accept  = data_valid & data_ready;

  // Counter is loaded with the state length on entry; leaving happens at 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      cs    <= 1'b1;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (goFrame) begin
          state <= LEAD;
          cnt   <= LEAD_CNT;
          cs    <= 1'b0;
          busy  <= 1'b1;
        end
        LEAD: if (cntDone) begin
          state <= SHIFT;
          cnt   <= RES_CNT;
        end else cnt <= cnt - ONE;
        SHIFT: if (cntDone) begin
          state <= TRAIL;
          cnt   <= TRAIL_CNT;
        end else cnt <= cnt - ONE;
        TRAIL: if (cntDone) begin
          state <= QUIET;
          cnt   <= QUIET_CNT;
          cs    <= 1'b1;
        end else cnt <= cnt - ONE;
        QUIET: if (cntDone) begin
          if (goFrame) begin
            state <= LEAD;
            cnt   <= LEAD_CNT;
            cs    <= 1'b0;
          end else begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end
        end else cnt <= cnt - ONE;
        default: begin
          state <= IDLE;
          cnt   <= '0;
          cs    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // A load coinciding with an accept hands the old value over cleanly.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else if (loadNow) begin
      data_valid <= 1'b1;
      if (data_valid && !data_ready) overrun <= 1'b1;
    end else if (accept) begin
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : gCh
    adc_s101_shift #(
      .ADC_RES    (ADC_RES),
      .MISO_INVERT(MISO_INVERT)
    ) uShift (
      .clk    (clk),
      .reset  (reset),
      .shiftEn(shiftEn),
      .load   (loadNow),
      .misoBit(miso[k]),
      .dataOut(chData[k])
    );
  end

  assign data_out = chData;

endmodule

// File: tb/tb_adc_s101_array.sv
// Bench for adc_s101_array: ADC pin models driven by cs, plus a sample scoreboard.
`timescale 1ns/1ps
module tb_adc_s101_array;
  import adc_s101_pkg::*;

  localparam int PERIOD_NS = 1_000_000_000 / REF_CLK_HZ;
  localparam int TL = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #(PERIOD_NS/2) clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: defaults, one channel, no inversion.
  logic       startA = 0, contA = 0, readyA = 0;
  logic [0:0] misoA = 0;
  logic       csA, dvA, ovA, busyA;
  logic [7:0] dataA;

  // Instance B: 12-bit, four channels, inverted.
  logic        startB = 0, contB = 0, readyB = 0;
  logic [3:0]  misoB = 0;
  logic        csB, dvB, ovB, busyB;
  logic [47:0] dataB;

  adc_s101_array #(.ADC_RES(8), .NUM_CH(1), .MISO_INVERT(1'b0)) dutA (
    .clk(clk), .reset(reset), .start(startA), .continuous(contA), .miso(misoA),
    .cs(csA), .data_out(dataA), .data_valid(dvA), .data_ready(readyA),
    .overrun(ovA), .busy(busyA));

  adc_s101_array #(.ADC_RES(12), .NUM_CH(4), .MISO_INVERT(1'b1)) dutB (
    .clk(clk), .reset(reset), .start(startB), .continuous(contB), .miso(misoB),
    .cs(csB), .data_out(dataB), .data_valid(dvB), .data_ready(readyB),
    .overrun(ovB), .busy(busyB));

  int checks = 0;
  int failures = 0;

  // ADC model A: counts cs-low cycles, presents bit MSB-first after the lead ticks.
  logic       aRand = 0;
  logic [7:0] aVal = 0, aNext;
  logic [7:0] aSent[$];
  int aIdx = 0;
  always @(negedge clk) begin
    if (csA) aIdx = 0;
    else begin
      if (aIdx == 0) begin
        if (aRand) begin
          do aNext = 8'($urandom); while (aNext == aVal);
          aVal = aNext;
        end
        aSent.push_back(aVal);
      end
      if (aIdx >= TL && aIdx < TL + 8) misoA[0] = aVal[7 - (aIdx - TL)];
      else misoA[0] = 1'($urandom);
      aIdx++;
    end
  end

  logic [11:0] bRaw [4];
  int bIdx = 0;
  always @(negedge clk) begin
    if (csB) bIdx = 0;
    else begin
      for (int k = 0; k < 4; k++)
        misoB[k] = (bIdx >= TL && bIdx < TL + 12) ? bRaw[k][11 - (bIdx - TL)] : 1'($urandom);
      bIdx++;
    end
  end

  task automatic waitIdleA(input string tag);
    int n = 0;
    while (busyA && n < 60) begin @(negedge clk); n++; end
    checks++;
    if (busyA) begin failures++; $display("FAIL %s idle timeout busy=%b exp=0", tag, busyA); end
  endtask

  task automatic waitValidA(input string tag);
    int n = 0;
    while (!dvA && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (!dvA) begin failures++; $display("FAIL %s valid timeout dv=%b exp=1", tag, dvA); end
  endtask

  task automatic test_reset;
    reset = 1;
    repeat (3) @(negedge clk);
    checks += 8;
    if (csA !== 1'b1)    begin failures++; $display("FAIL rst csA got=%b exp=1", csA); end
    if (dataA !== 8'h00) begin failures++; $display("FAIL rst dataA got=%h exp=00", dataA); end
    if (dvA !== 1'b0)    begin failures++; $display("FAIL rst dvA got=%b exp=0", dvA); end
    if (ovA !== 1'b0)    begin failures++; $display("FAIL rst ovA got=%b exp=0", ovA); end
    if (busyA !== 1'b0)  begin failures++; $display("FAIL rst busyA got=%b exp=0", busyA); end
    if (csB !== 1'b1)    begin failures++; $display("FAIL rst csB got=%b exp=1", csB); end
    if (dataB !== 48'h0) begin failures++; $display("FAIL rst dataB got=%h exp=0", dataB); end
    if (dvB !== 1'b0)    begin failures++; $display("FAIL rst dvB got=%b exp=0", dvB); end
    reset = 0;
    @(negedge clk);
  endtask

  task automatic test_single_frame(input logic [7:0] val);
    logic expCs, expBusy, expDv;
    aRand = 0; aVal = val; readyA = 0;
    startA = 1;
    @(negedge clk);
    startA = 0;
    for (int c = 1; c <= 22; c++) begin
      expCs = (c <= 16) ? 1'b0 : 1'b1;
      expBusy = (c <= 20) ? 1'b1 : 1'b0;
      expDv = (c >= 17) ? 1'b1 : 1'b0;
      checks += 3;
      if (csA !== expCs)     begin failures++; $display("FAIL frame cs c=%0d got=%b exp=%b", c, csA, expCs); end
      if (busyA !== expBusy) begin failures++; $display("FAIL frame busy c=%0d got=%b exp=%b", c, busyA, expBusy); end
      if (dvA !== expDv)     begin failures++; $display("FAIL frame dv c=%0d got=%b exp=%b", c, dvA, expDv); end
      if (c == 17) begin
        checks++;
        if (dataA !== val) begin failures++; $display("FAIL frame data got=%h exp=%h", dataA, val); end
      end
      @(negedge clk);
    end
    readyA = 1;
    @(negedge clk);
    readyA = 0;
    checks += 3;
    if (dvA !== 1'b0)  begin failures++; $display("FAIL accept dv got=%b exp=0", dvA); end
    if (ovA !== 1'b0)  begin failures++; $display("FAIL accept ov got=%b exp=0", ovA); end
    if (dataA !== val) begin failures++; $display("FAIL accept data hold got=%h exp=%h", dataA, val); end
  endtask

  task automatic test_multich;
    int n;
    for (int it = 0; it < 2; it++) begin
      if (it == 0) begin
        bRaw[0] = 12'h000; bRaw[1] = 12'hFFF; bRaw[2] = 12'h5A5; bRaw[3] = 12'h3C3;
      end else
        for (int k = 0; k < 4; k++) bRaw[k] = 12'($urandom);
      startB = 1;
      @(negedge clk);
      startB = 0;
      n = 0;
      while (!dvB && n < 40) begin @(negedge clk); n++; end
      checks++;
      if (!dvB) begin failures++; $display("FAIL multich valid timeout dv=%b exp=1", dvB); end
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (dataB[k*12 +: 12] !== ~bRaw[k]) begin
          failures++;
          $display("FAIL multich ch%0d got=%h exp=%h", k, dataB[k*12 +: 12], ~bRaw[k]);
        end
      end
      readyB = 1;
      @(negedge clk);
      readyB = 0;
      n = 0;
      while (busyB && n < 40) begin @(negedge clk); n++; end
    end
  endtask

  task automatic test_continuous;
    logic prevCs = 1'b1;
    int lastFall = -1;
    int accepts = 0;
    logic [7:0] exp;
    aRand = 1; aSent.delete(); readyA = 1; contA = 1;
    for (int i = 0; i < 300 && accepts < 10; i++) begin
      @(negedge clk);
      if (prevCs && !csA) begin
        if (lastFall >= 0) begin
          checks++;
          if (cyc - lastFall != 20) begin failures++; $display("FAIL cont period got=%0d exp=20", cyc - lastFall); end
        end
        lastFall = cyc;
      end
      prevCs = csA;
      if (dvA && readyA) begin
        exp = (aSent.size() > 0) ? aSent.pop_front() : ~dataA;
        checks++;
        if (dataA !== exp) begin failures++; $display("FAIL cont sample%0d got=%h exp=%h", accepts, dataA, exp); end
        accepts++;
      end
    end
    checks += 2;
    if (accepts != 10) begin failures++; $display("FAIL cont accepts got=%0d exp=10", accepts); end
    if (ovA !== 1'b0)  begin failures++; $display("FAIL cont overrun got=%b exp=0", ovA); end
    contA = 0;
    waitIdleA("cont");
    readyA = 0;
  endtask

  task automatic test_overrun;
    logic prevCs;
    int comp = 0;
    logic [7:0] exp;
    aRand = 1; aSent.delete(); readyA = 0; contA = 1;
    prevCs = csA;
    for (int i = 0; i < 100 && comp < 3; i++) begin
      @(negedge clk);
      if (!prevCs && csA) begin
        comp++;
        exp = (aSent.size() > 0) ? aSent.pop_front() : ~dataA;
        checks += 3;
        if (dataA !== exp) begin failures++; $display("FAIL ovr data f%0d got=%h exp=%h", comp, dataA, exp); end
        if (dvA !== 1'b1)  begin failures++; $display("FAIL ovr dv f%0d got=%b exp=1", comp, dvA); end
        if (ovA !== (comp >= 2)) begin failures++; $display("FAIL ovr flag f%0d got=%b exp=%b", comp, ovA, comp >= 2); end
        if (comp == 3) contA = 0;
      end
      prevCs = csA;
    end
    checks++;
    if (comp != 3) begin failures++; $display("FAIL ovr completions got=%0d exp=3", comp); end
    @(negedge clk);
    readyA = 1;
    @(negedge clk);
    readyA = 0;
    checks += 2;
    if (dvA !== 1'b0) begin failures++; $display("FAIL ovr clear dv got=%b exp=0", dvA); end
    if (ovA !== 1'b0) begin failures++; $display("FAIL ovr clear ov got=%b exp=0", ovA); end
    waitIdleA("ovr");
  endtask

  task automatic test_back_to_back;
    logic prevCs = 1'b1;
    int n = 0;
    logic [7:0] s1, s2;
    aRand = 1; aSent.delete(); readyA = 0; contA = 1;
    while (!(!prevCs && csA) && n < 60) begin prevCs = csA; @(negedge clk); n++; end
    s1 = (aSent.size() > 0) ? aSent.pop_front() : ~dataA;
    checks += 2;
    if (dvA !== 1'b1) begin failures++; $display("FAIL b2b first dv got=%b exp=1", dvA); end
    if (dataA !== s1) begin failures++; $display("FAIL b2b first data got=%h exp=%h", dataA, s1); end
    repeat (19) @(negedge clk);
    readyA = 1;
    @(negedge clk);
    readyA = 0;
    contA = 0;
    s2 = (aSent.size() > 0) ? aSent.pop_front() : ~dataA;
    checks += 4;
    if (csA !== 1'b1) begin failures++; $display("FAIL b2b cs got=%b exp=1", csA); end
    if (dvA !== 1'b1) begin failures++; $display("FAIL b2b dv got=%b exp=1", dvA); end
    if (dataA !== s2) begin failures++; $display("FAIL b2b data got=%h exp=%h", dataA, s2); end
    if (ovA !== 1'b0) begin failures++; $display("FAIL b2b ov got=%b exp=0", ovA); end
    waitIdleA("b2b");
    readyA = 1;
    @(negedge clk);
    readyA = 0;
  endtask

  task automatic test_reset_midframe;
    logic [7:0] exp;
    aRand = 1; aSent.delete(); readyA = 0;
    startA = 1;
    @(negedge clk);
    startA = 0;
    waitValidA("rstmid pre");
    waitIdleA("rstmid pre");
    startA = 1;
    @(negedge clk);
    startA = 0;
    repeat (6) @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    checks += 5;
    if (csA !== 1'b1)    begin failures++; $display("FAIL rstmid cs got=%b exp=1", csA); end
    if (dvA !== 1'b0)    begin failures++; $display("FAIL rstmid dv got=%b exp=0", dvA); end
    if (busyA !== 1'b0)  begin failures++; $display("FAIL rstmid busy got=%b exp=0", busyA); end
    if (ovA !== 1'b0)    begin failures++; $display("FAIL rstmid ov got=%b exp=0", ovA); end
    if (dataA !== 8'h00) begin failures++; $display("FAIL rstmid data got=%h exp=00", dataA); end
    startA = 1;
    @(negedge clk);
    startA = 0;
    waitValidA("rstmid fresh");
    exp = (aSent.size() > 0) ? aSent[$] : ~dataA;
    checks++;
    if (dataA !== exp) begin failures++; $display("FAIL rstmid fresh data got=%h exp=%h", dataA, exp); end
    waitIdleA("rstmid fresh");
  endtask

  initial begin
    #(PERIOD_NS * 20000);
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 4; k++) bRaw[k] = '0;
    test_reset;
    test_single_frame(8'hA5);
    test_single_frame(8'($urandom));
    test_multich;
    test_continuous;
    test_overrun;
    test_back_to_back;
    test_reset_midframe;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
